// File: rtl/wb_regfile.sv
// Write-back select, 32-entry register file and saturating commit counter.
// Optional same-cycle read bypass on rs/rt ports: define WB_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W = 32,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_wb,
  input  logic              MemToReg_wb,
  input  logic [DATA_W-1:0] read_data_wb,
  input  logic [DATA_W-1:0] alu_result_wb,
  input  logic [AW-1:0]     dest_reg_wb,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit,
  output logic [CNT_W-1:0]  commit_cnt
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;
  logic [DATA_W-1:0] rs_arr;
  logic [DATA_W-1:0] rt_arr;

  assign wb_data = MemToReg_wb ? read_data_wb
                               : alu_result_wb;
  assign wr_en = RegWrite_wb && (dest_reg_wb != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[dest_reg_wb] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_commit  <= 1'b0;
      commit_cnt <= '0;
    end else begin
      wb_commit <= wr_en;
      if (wr_en && (commit_cnt != '1)) begin
        commit_cnt <= commit_cnt + CNT_W'(1);
      end
    end
  end

  // Index 0 is forced to zero on reads regardless of array contents.
  assign rs_arr = (rs_addr == '0) ? '0
                                  : regs[rs_addr];
  assign rt_arr = (rt_addr == '0) ? '0
                                  : regs[rt_addr];
  assign dbg_data = (dbg_addr == '0) ? '0
                                     : regs[dbg_addr];

`ifdef WB_BYPASS_EN
  assign rs_data = (wr_en && rs_addr == dest_reg_wb)
                 ? wb_data : rs_arr;
  assign rt_data = (wr_en && rt_addr == dest_reg_wb)
                 ? wb_data : rt_arr;
`else
  assign rs_data = rs_arr;
  assign rt_data = rt_arr;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus reset,
// same-cycle hazard and counter saturation sequences.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic        m2r;
  logic [31:0] rdat;
  logic [31:0] alu;
  logic [4:0]  dest;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [4:0]  dbg_a;
  logic [31:0] rs_d;
  logic [31:0] rt_d;
  logic [31:0] dbg_d;
  logic [31:0] wbd;
  logic        cmt;
  logic [31:0] cnt;
  logic [31:0] rs_d4;
  logic [31:0] rt_d4;
  logic [31:0] dbg_d4;
  logic [31:0] wbd4;
  logic        cmt4;
  logic [3:0]  cnt4;

  int nvec = 0;
  int nerr = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .RegWrite_wb(we), .MemToReg_wb(m2r),
    .read_data_wb(rdat), .alu_result_wb(alu),
    .dest_reg_wb(dest),
    .rs_addr(rs_a), .rt_addr(rt_a),
    .rs_data(rs_d), .rt_data(rt_d),
    .dbg_addr(dbg_a), .dbg_data(dbg_d),
    .wb_data(wbd), .wb_commit(cmt),
    .commit_cnt(cnt)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .RegWrite_wb(we), .MemToReg_wb(m2r),
    .read_data_wb(rdat), .alu_result_wb(alu),
    .dest_reg_wb(dest),
    .rs_addr(rs_a), .rt_addr(rt_a),
    .rs_data(rs_d4), .rt_data(rt_d4),
    .dbg_addr(dbg_a), .dbg_data(dbg_d4),
    .wb_data(wbd4), .wb_commit(cmt4),
    .commit_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [31:0] wb;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_dbg;
    logic        e_cmt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic w,
                       input logic m,
                       input logic [31:0] r,
                       input logic [31:0] a,
                       input logic [4:0] d);
    we = w; m2r = m; rdat = r; alu = a; dest = d;
  endtask

  task automatic edge_idle();
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{1, 0, 32'h0, 32'h1234, 3, 32'h1234,
                3, 0, 3, 32'h1234, 32'h0, 32'h1234, 1, 1};
    vecs[1] = '{1, 1, 32'hCAFEF00D, 32'h1, 31,
                32'hCAFEF00D, 3, 31, 31, 32'h1234,
                32'hCAFEF00D, 32'hCAFEF00D, 1, 2};
    vecs[2] = '{1, 0, 32'h0, 32'hFFFFFFFF, 0,
                32'hFFFFFFFF, 0, 0, 0, 32'h0, 32'h0,
                32'h0, 0, 2};
    vecs[3] = '{0, 0, 32'h0, 32'h55, 4, 32'h55,
                4, 4, 4, 32'h0, 32'h0, 32'h0, 0, 2};
    vecs[4] = '{1, 0, 32'h9, 32'h11, 7, 32'h11,
                7, 3, 7, 32'h11, 32'h1234, 32'h11, 1, 3};
    vecs[5] = '{1, 1, 32'hDEADBEEF, 32'h0, 5,
                32'hDEADBEEF, 5, 7, 0, 32'hDEADBEEF,
                32'h11, 32'h0, 1, 4};
    vecs[6] = '{1, 0, 32'h0, 32'h100, 9, 32'h100,
                9, 9, 9, 32'h100, 32'h100, 32'h100, 1, 5};
    vecs[7] = '{1, 0, 32'h0, 32'h200, 9, 32'h200,
                9, 9, 9, 32'h200, 32'h200, 32'h200, 1, 6};

    rst = 1'b0;
    drive(0, 1, 32'h0BAD0001, 32'h0BAD0002, 0);
    rs_a = 5; rt_a = 31; dbg_a = 3;
    #12;
    chk("rst rs_data", rs_d, 32'h0);
    chk("rst rt_data", rt_d, 32'h0);
    chk("rst dbg_data", dbg_d, 32'h0);
    chk("rst wb_data", wbd, 32'h0BAD0001);
    chk("rst wb_commit", 32'(cmt), 32'h0);
    chk("rst commit_cnt", cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].we, vecs[i].m2r, vecs[i].rd,
            vecs[i].alu, vecs[i].dest);
      #1;
      chk($sformatf("v%0d wb_data", i), wbd,
          vecs[i].wb);
      edge_idle();
      rs_a = vecs[i].rs;
      rt_a = vecs[i].rt;
      dbg_a = vecs[i].dbg;
      #1;
      chk($sformatf("v%0d rs_data", i), rs_d,
          vecs[i].e_rs);
      chk($sformatf("v%0d rt_data", i), rt_d,
          vecs[i].e_rt);
      chk($sformatf("v%0d dbg_data", i), dbg_d,
          vecs[i].e_dbg);
      chk($sformatf("v%0d wb_commit", i),
          32'(cmt), 32'(vecs[i].e_cmt));
      chk($sformatf("v%0d commit_cnt", i), cnt,
          vecs[i].e_cnt);
      chk($sformatf("v%0d commit_cnt4", i),
          32'(cnt4), vecs[i].e_cnt);
    end

    // same-cycle write/read of x7 (old value 0x11)
    rs_a = 7; dbg_a = 7; rt_a = 0;
    drive(1, 0, 32'h0, 32'hA5A5A5A5, 7);
    #1;
`ifdef WB_BYPASS_EN
    chk("hz rs pre-edge", rs_d, 32'hA5A5A5A5);
`else
    chk("hz rs pre-edge", rs_d, 32'h11);
`endif
    chk("hz dbg pre-edge", dbg_d, 32'h11);
    edge_idle();
    chk("hz rs post-edge", rs_d, 32'hA5A5A5A5);
    chk("hz cnt", cnt, 32'd7);

    rs_a = 0;
    drive(1, 0, 32'h0, 32'hFFFFFFFF, 0);
    #1;
    chk("r0 rs pre-edge", rs_d, 32'h0);
    edge_idle();
    chk("r0 commit", 32'(cmt), 32'h0);
    chk("r0 cnt", cnt, 32'd7);

    rs_a = 10;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h0, 32'h1000 + 32'(i), 10);
      edge_idle();
      chk($sformatf("sat%0d rs", i), rs_d,
          32'h1000 + 32'(i));
      chk($sformatf("sat%0d commit4", i),
          32'(cmt4), 32'h1);
      chk($sformatf("sat%0d cnt", i), cnt,
          32'd8 + 32'(i));
      chk($sformatf("sat%0d cnt4", i), 32'(cnt4),
          (i < 7) ? 32'd8 + 32'(i) : 32'd15);
    end
    drive(1, 0, 32'h0, 32'h1, 0);
    edge_idle();
    chk("sat r0 cnt4", 32'(cnt4), 32'd15);
    chk("sat r0 commit4", 32'(cmt4), 32'h0);

    // asynchronous reset right after a write
    rs_a = 5; rt_a = 10;
    drive(1, 0, 32'h0, 32'h42, 12);
    @(posedge clk);
    #2;
    we = 1'b0;
    chk("mid pre commit", 32'(cmt), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid rs x5", rs_d, 32'h0);
    chk("mid rt x10", rt_d, 32'h0);
    chk("mid commit", 32'(cmt), 32'h0);
    chk("mid cnt", cnt, 32'h0);
    chk("mid cnt4", 32'(cnt4), 32'h0);
    rs_a = 6;
    drive(1, 0, 32'h0, 32'h77, 6);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("inrst rs x6", rs_d, 32'h0);
    chk("inrst cnt", cnt, 32'h0);
    chk("inrst commit", 32'(cmt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    edge_idle();
    chk("post rs x6", rs_d, 32'h77);
    chk("post cnt", cnt, 32'h1);
    chk("post commit", 32'(cmt), 32'h1);
    @(posedge clk);
    #1;
    chk("post commit drop", 32'(cmt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file; consumes the MEM/WB pipeline register outputs.
- Selects write-back data (memory load vs ALU result), commits it to a 32x32 register file, and serves two combinational read ports to ID plus one debug read port.
- Keeps a saturating count of committed register writes for the performance and debug harness.

Parameters:
- DATA_W, 32, register and data width
- NUM_REGS, 32, number of architectural registers; index width = clog2(NUM_REGS) = 5
- CNT_W, 32, width of the write-commit counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset (asserted when 0)
- RegWrite_wb  input  1  write enable from MEM/WB register
- MemToReg_wb  input  1  1 selects read_data_wb, 0 selects alu_result_wb
- read_data_wb  input  DATA_W  load data from MEM/WB
- alu_result_wb  input  DATA_W  ALU result from MEM/WB
- dest_reg_wb  input  5  destination register index
- rs_addr  input  5  read port A address (ID stage)
- rt_addr  input  5  read port B address (ID stage)
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- dbg_addr  input  5  debug read address
- dbg_data  output  DATA_W  debug read data (never bypassed)
- wb_data  output  DATA_W  selected write-back value (combinational, for EX forwarding)
- wb_commit  output  1  registered pulse: a real write committed on the previous edge
- commit_cnt  output  CNT_W  count of committed writes

Behaviour:
- wb_data = MemToReg_wb ? read_data_wb : alu_result_wb. Purely combinational, independent of RegWrite_wb.
- A write is effective when RegWrite_wb=1 and dest_reg_wb!=0.
- Effective write: regs[dest_reg_wb] <= wb_data on the rising edge.
- Register 0 is hardwired to zero. Writes to index 0 are dropped and do not count as commits. Reads of index 0 return 0 on every port.
- Reads are asynchronous (combinational) from the current array contents.
- wb_commit is registered: 1 for exactly the cycle after each effective write edge, else 0.
- commit_cnt increments by 1 on each effective write edge.
  - Saturates at all-ones and never wraps.
  - 2^CNT_W-1 holds; a further write leaves it unchanged.
- Reset (rst=0, asynchronous, any time including mid-stream):
  - all registers = 0, wb_commit = 0, commit_cnt = 0 immediately, without waiting for clk.
  - While rst=0, writes are ignored.
  - First write is accepted on the first rising edge after rst returns to 1.
- Back-to-back writes to the same register: the last write wins. Each one counts.
- Reset values of outputs:
  - rs_data, rt_data and dbg_data read 0 (array cleared).
  - wb_data follows its inputs.
  - wb_commit = 0, commit_cnt = 0.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined: internal write-before-read bypass on rs_data and rt_data.
  - Condition: effective write this cycle and read address == dest_reg_wb (nonzero).
  - Result: the port returns wb_data in the same cycle instead of the stale array value.
  - dbg_data is never bypassed.
- When undefined: rs_data and rt_data always reflect array contents. The same-cycle reader sees the old value, and the hazard unit must stall one cycle.

Test Plan:
- Reset: hold rst=0 mid-run after writing x5=0xDEADBEEF -> immediately rs_data(5)=0, commit_cnt=0, wb_commit=0. Writes during reset are ignored.
- ALU write then read: RegWrite=1, MemToReg=0, alu_result=0x0000_1234, dest=3, edge -> rs_data(3)=0x1234, wb_commit=1 for one cycle, commit_cnt=1.
- Load write: MemToReg=1, read_data=0xCAFEF00D, alu_result=0x1, dest=31 -> rt_data(31)=0xCAFEF00D, dbg_data(31) matches.
- r0 protection: RegWrite=1, dest=0, data=0xFFFFFFFF -> rs_data(0)=0, wb_commit=0, commit_cnt unchanged.
- Same-cycle read/write, dest=7=rs_addr, alu_result=0xA5A5A5A5, old x7=0x11:
  - WB_BYPASS_EN defined -> rs_data=0xA5A5A5A5 before the edge.
  - undefined -> rs_data=0x11 before the edge, 0xA5A5A5A5 after.
- Counter saturation with CNT_W=4: 17 effective writes -> commit_cnt goes 1..15, then stays 15. wb_commit still pulses each time.
